// File: rtl/cache_pkg.sv
// Shared definitions for the cache and its refill controller: block geometry
// defaults, refill FSM states and address-split helpers.
package cache_pkg;

  localparam int unsigned CACHE_RAM_ADDRESS_BITS = 10;
  localparam int unsigned CACHE_DATA_WIDTH       = 32;
  localparam int unsigned CACHE_BLOCK_BITS       = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } refill_state_t;

  typedef logic [CACHE_RAM_ADDRESS_BITS-1:0] cache_addr_t;

  function automatic cache_addr_t block_base(input cache_addr_t addr);
    return {addr[CACHE_RAM_ADDRESS_BITS-1:CACHE_BLOCK_BITS], {CACHE_BLOCK_BITS{1'b0}}};
  endfunction

  function automatic logic [CACHE_BLOCK_BITS-1:0] block_offset(input cache_addr_t addr);
    return addr[CACHE_BLOCK_BITS-1:0];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss handler between cache and RAM: optional write-through beat, then a
// critical-word-first wrapping block refill, ending with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for miss / write-through request
// WRITE | single RAM write beat for write-through
// FILL  | read beats, critical word first, offset wraps inside the block
// DONE  | fill_done pulse; cache drops its request here
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = CACHE_RAM_ADDRESS_BITS,
  parameter int DATA_WIDTH       = CACHE_DATA_WIDTH,
  parameter int BLOCK_BITS       = CACHE_BLOCK_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        miss,
  input  logic [RAM_ADDRESS_BITS-1:0] prop_address,
  input  logic [DATA_WIDTH-1:0]       prop_write_data,
  input  logic                        prop_write_en,
  output logic                        ram_req,
  output logic [RAM_ADDRESS_BITS-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_wdata,
  output logic                        ram_we,
  input  logic                        ram_ack,
  input  logic [DATA_WIDTH-1:0]       ram_rdata,
  output logic                        fill_valid,
  output logic [BLOCK_BITS-1:0]       fill_offset,
  output logic [DATA_WIDTH-1:0]       fill_data,
  output logic                        fill_done,
  output logic                        busy
);

  refill_state_t               state_q, state_d;
  logic [RAM_ADDRESS_BITS-1:0] addr_q, addr_d;
  logic                        miss_q, miss_d;
  logic [BLOCK_BITS-1:0]       off_q, off_d;
  logic [BLOCK_BITS-1:0]       cnt_q, cnt_d;
  logic                        ram_req_q, ram_req_d;
  logic [RAM_ADDRESS_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]       ram_wdata_q, ram_wdata_d;
  logic                        ram_we_q, ram_we_d;
  logic                        fill_valid_q, fill_valid_d;
  logic [BLOCK_BITS-1:0]       fill_offset_q, fill_offset_d;
  logic [DATA_WIDTH-1:0]       fill_data_q, fill_data_d;
  logic                        fill_done_q, fill_done_d;
  logic                        busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      miss_q        <= 1'b0;
      off_q         <= '0;
      cnt_q         <= '0;
      ram_req_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
      fill_valid_q  <= 1'b0;
      fill_offset_q <= '0;
      fill_data_q   <= '0;
      fill_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      miss_q        <= miss_d;
      off_q         <= off_d;
      cnt_q         <= cnt_d;
      ram_req_q     <= ram_req_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_we_q      <= ram_we_d;
      fill_valid_q  <= fill_valid_d;
      fill_offset_q <= fill_offset_d;
      fill_data_q   <= fill_data_d;
      fill_done_q   <= fill_done_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    miss_d        = miss_q;
    off_d         = off_q;
    cnt_d         = cnt_q;
    ram_req_d     = ram_req_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_we_d      = ram_we_q;
    fill_valid_d  = 1'b0;
    fill_offset_d = fill_offset_q;
    fill_data_d   = fill_data_q;

    unique case (state_q)
      IDLE: begin
        if (miss || prop_write_en) begin
          addr_d      = prop_address;
          miss_d      = miss;
          off_d       = prop_address[BLOCK_BITS-1:0];
          cnt_d       = '1;
          ram_req_d   = 1'b1;
          ram_addr_d  = prop_address;
          ram_wdata_d = prop_write_data;
          ram_we_d    = prop_write_en;
          state_d     = prop_write_en ? WRITE : FILL;
        end
      end
      WRITE: begin
        if (ram_ack) begin
          ram_we_d = 1'b0;
          if (miss_q) begin
            ram_addr_d = addr_q;
            state_d    = FILL;
          end else begin
            ram_req_d = 1'b0;
            state_d   = DONE;
          end
        end
      end
      FILL: begin
        if (ram_ack) begin
          fill_valid_d  = 1'b1;
          fill_data_d   = ram_rdata;
          fill_offset_d = off_q;
          off_d         = off_q + 1'b1;
          cnt_d         = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            ram_req_d = 1'b0;
            state_d   = DONE;
          end else begin
            // Only the offset wraps; the block base is never carried into.
            ram_addr_d = {addr_q[RAM_ADDRESS_BITS-1:BLOCK_BITS], off_q + 1'b1};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    fill_done_d = (state_d == DONE);
  end

  assign ram_req     = ram_req_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign fill_valid  = fill_valid_q;
  assign fill_offset = fill_offset_q;
  assign fill_data   = fill_data_q;
  assign fill_done   = fill_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus random
// transactions compared against a block-level model of the refill sequence.
module tb_cache_refill_ctrl;

  localparam int RA = 10;
  localparam int DW = 32;
  localparam int BB = 2;
  localparam int NW = 4;

  typedef struct packed {
    logic          we;
    logic [RA-1:0] addr;
    logic [DW-1:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [BB-1:0] off;
    logic [DW-1:0] data;
  } fill_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss;
  logic [RA-1:0] prop_address;
  logic [DW-1:0] prop_write_data;
  logic          prop_write_en;
  logic          ram_req;
  logic [RA-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_ack;
  logic [DW-1:0] ram_rdata;
  logic          fill_valid;
  logic [BB-1:0] fill_offset;
  logic [DW-1:0] fill_data;
  logic          fill_done;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl #(
    .RAM_ADDRESS_BITS(RA),
    .DATA_WIDTH      (DW),
    .BLOCK_BITS      (BB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .miss           (miss),
    .prop_address   (prop_address),
    .prop_write_data(prop_write_data),
    .prop_write_en  (prop_write_en),
    .ram_req        (ram_req),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_we         (ram_we),
    .ram_ack        (ram_ack),
    .ram_rdata      (ram_rdata),
    .fill_valid     (fill_valid),
    .fill_offset    (fill_offset),
    .fill_data      (fill_data),
    .fill_done      (fill_done),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ramval(input logic [RA-1:0] a, input logic [DW-1:0] s);
    return (32'(a) + 32'h100) ^ s;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_req"},     ram_req,     '0);
    check({tag, "_ram_addr"},    ram_addr,    '0);
    check({tag, "_ram_wdata"},   ram_wdata,   '0);
    check({tag, "_ram_we"},      ram_we,      '0);
    check({tag, "_fill_valid"},  fill_valid,  '0);
    check({tag, "_fill_offset"}, fill_offset, '0);
    check({tag, "_fill_data"},   fill_data,   '0);
    check({tag, "_fill_done"},   fill_done,   '0);
    check({tag, "_busy"},        busy,        '0);
  endtask

  // Called at posedge+1 with the DUT idle. Per-beat wait states drawn from [wmin,wmax].
  task automatic run_txn(input logic m, input logic w, input logic [RA-1:0] a,
                         input logic [DW-1:0] d, input int wmin, input int wmax,
                         input logic [DW-1:0] salt);
    beat_t exp_b[$];
    beat_t obs_b[$];
    fill_t exp_f[$];
    fill_t obs_f[$];
    int    waits[$];
    int    off, base, exp_done, cyc, bi, wc, done_cyc, last_fill, wthis;
    logic  pend;
    logic [RA-1:0] paddr;
    logic [RA-1:0] ai;

    off  = int'(a) % NW;
    base = int'(a) - off;
    if (w) exp_b.push_back('{we: 1'b1, addr: a, wdata: d});
    if (m) begin
      for (int i = 0; i < NW; i++) begin
        ai = RA'(base + (off + i) % NW);
        exp_b.push_back('{we: 1'b0, addr: ai, wdata: '0});
        exp_f.push_back('{off: BB'((off + i) % NW), data: ramval(ai, salt)});
      end
    end
    exp_done = 1;
    foreach (exp_b[i]) begin
      waits.push_back(int'($urandom_range(wmax, wmin)));
      exp_done += waits[i] + 1;
    end

    miss            = m;
    prop_write_en   = w;
    prop_address    = a;
    prop_write_data = d;
    ram_ack         = 1'b0;
    @(posedge clk); #1;

    cyc = 1; bi = 0; wc = 0; done_cyc = -1; last_fill = -1; pend = 1'b0; paddr = '0;
    while (cyc <= 200) begin
      check("busy_active", busy, 1'b1);
      if (pend && ram_req) check("addr_stable_in_wait", ram_addr, paddr);
      if (fill_valid) begin
        obs_f.push_back('{off: fill_offset, data: fill_data});
        last_fill = cyc;
      end
      if (fill_done) begin
        done_cyc      = cyc;
        miss          = 1'b0;
        prop_write_en = 1'b0;
        ram_ack       = 1'b0;
        break;
      end
      if (ram_req) begin
        wthis = (bi < waits.size()) ? waits[bi] : 0;
        if (wc >= wthis) begin
          ram_ack   = 1'b1;
          ram_rdata = ramval(ram_addr, salt);
          obs_b.push_back('{we: ram_we, addr: ram_addr, wdata: ram_wdata});
          bi++;
          wc   = 0;
          pend = 1'b0;
        end else begin
          ram_ack   = 1'b0;
          ram_rdata = $urandom;
          wc++;
          pend  = 1'b1;
          paddr = ram_addr;
        end
      end else begin
        ram_ack   = 1'($urandom_range(1, 0));
        ram_rdata = $urandom;
        pend      = 1'b0;
      end
      prop_address    = RA'($urandom);
      prop_write_data = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    miss          = 1'b0;
    prop_write_en = 1'b0;

    check("done_cycle", done_cyc, exp_done);
    if (m) check("last_fill_with_done", last_fill, exp_done);

    check("beat_count", obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      check("beat_we",   obs_b[i].we,   exp_b[i].we);
      check("beat_addr", obs_b[i].addr, exp_b[i].addr);
      if (exp_b[i].we) check("beat_wdata", obs_b[i].wdata, exp_b[i].wdata);
    end
    check("fill_count", obs_f.size(), exp_f.size());
    for (int i = 0; i < exp_f.size() && i < obs_f.size(); i++) begin
      check("fill_offset", obs_f[i].off,  exp_f[i].off);
      check("fill_data",   obs_f[i].data, exp_f[i].data);
    end

    // Spurious acks while idle must not start anything.
    for (int k = 0; k < 3; k++) begin
      ram_ack = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      check("idle_busy",       busy,       1'b0);
      check("idle_ram_req",    ram_req,    1'b0);
      check("idle_fill_valid", fill_valid, 1'b0);
      check("idle_fill_done",  fill_done,  1'b0);
    end
    ram_ack = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    miss            = 1'b0;
    prop_write_en   = 1'b0;
    prop_address    = '0;
    prop_write_data = '0;
    ram_ack         = 1'b0;
    ram_rdata       = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    run_txn(1'b1, 1'b0, 10'h00D, 32'h0, 0, 0, 32'h0);
    run_txn(1'b0, 1'b1, 10'h3FF, 32'hDEADBEEF, 0, 0, 32'h0);
    run_txn(1'b1, 1'b1, 10'h020, 32'h12345678, 2, 2, 32'h0);

    // Reset during the third read beat of a refill at 0x2A.
    miss         = 1'b1;
    prop_address = 10'h02A;
    ram_ack      = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      ram_ack   = 1'b1;
      ram_rdata = ramval(ram_addr, 32'h0);
      @(posedge clk); #1;
    end
    check("third_beat_req",  ram_req,  1'b1);
    check("third_beat_addr", ram_addr, 10'h028);
    ram_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    miss = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_mid_reset");
    run_txn(1'b1, 1'b0, 10'h100, 32'h0, 0, 0, 32'h0);

    for (int t = 0; t < 12; t++) begin
      int kind;
      kind = int'($urandom_range(2, 0));
      run_txn(kind != 1, kind != 0, RA'($urandom), $urandom, 0, 3, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
